// File: rtl/escalonador_pkg.sv
// Shared types and constants for the round-robin process scheduler.
package escalonador_pkg;

  // Width of a process id on the external interface.
  localparam int PROC_ID_W = 10;

  // Largest number of process slots the scheduler is built for.
  localparam int NUM_PROC_MAX = 5;

  // Scheduler states.
  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    SWITCH,
    RUN
  } state_t;

endpackage

// File: rtl/escalonador_rr_arbiter.sv
// Combinational round-robin picker: finds the first candidate at or after
// the start id, wrapping around. Without the include flag the start id
// itself is only considered last.
module rr_arbiter
  import escalonador_pkg::*;
#(
  parameter int NUM_PROC = 5
) (
  input  logic [NUM_PROC-1:0]  i_cand,
  input  logic [PROC_ID_W-1:0] i_start,
  input  logic                 i_incl,
  output logic [PROC_ID_W-1:0] o_pick,
  output logic                 o_valid
);

  localparam logic [PROC_ID_W:0] N_EXT = (PROC_ID_W+1)'(NUM_PROC);

  logic [PROC_ID_W:0]    w_base;
  logic [PROC_ID_W:0]    w_ofs;
  logic [PROC_ID_W:0]    w_sum;
  logic [2*NUM_PROC-1:0] w_dbl;
  logic [NUM_PROC-1:0]   w_rot;

  // Rotate the candidate mask so the first id to try sits at bit 0, take
  // the lowest set bit, then rotate the result back into an absolute id.
  always_comb begin
    w_base = {1'b0, i_start} + {{PROC_ID_W{1'b0}}, ~i_incl};
    if (w_base >= N_EXT) w_base = w_base - N_EXT;
    w_dbl = {i_cand, i_cand} >> w_base;
    w_rot = w_dbl[NUM_PROC-1:0];
    w_ofs = '0;
    for (int j = NUM_PROC - 1; j >= 0; j--) begin
      if (w_rot[j]) w_ofs = (PROC_ID_W+1)'(j);
    end
    w_sum = w_base + w_ofs;
    if (w_sum >= N_EXT) w_sum = w_sum - N_EXT;
    o_pick  = w_sum[PROC_ID_W-1:0];
    o_valid = |i_cand;
  end

endmodule

// File: rtl/escalonador.sv
// Round-robin process scheduler. Counts retired instructions of the running
// process and requests a context switch on quantum expiry, process end or
// process deactivation. Finished processes stay masked until their active
// bit drops.
// Optional: define ESCALONADOR_STATS_EN to add the trocas_cnt output that
// counts accepted context switches.
module escalonador
  import escalonador_pkg::*;
#(
  parameter int NUM_PROC  = 5,
  parameter int QUANTUM_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PROC-1:0]  proc_ativo,
  input  logic [QUANTUM_W-1:0] quantum,
  input  logic                 instr_done,
  input  logic                 proc_fim,
  input  logic                 troca_ack,
  output logic                 troca_req,
  output logic [PROC_ID_W-1:0] hd_set,
  output logic [PROC_ID_W-1:0] processo_atual,
  output logic                 ocioso
`ifdef ESCALONADOR_STATS_EN
  ,
  output logic [15:0]          trocas_cnt
`endif
);

  state_t               r_state;
  logic                 r_trocaReq;
  logic [PROC_ID_W-1:0] r_hdSet;
  logic [PROC_ID_W-1:0] r_procAtual;
  logic                 r_ocioso;
  logic [QUANTUM_W-1:0] r_cnt;
  logic [NUM_PROC-1:0]  r_fimMask;
  logic                 r_first;
  logic                 r_needLoad;

  logic [NUM_PROC-1:0]  w_cand;
  logic [NUM_PROC-1:0]  w_curOneHot;
  logic                 w_curAtivo;
  logic [QUANTUM_W-1:0] w_qLast;
  logic [PROC_ID_W-1:0] w_pick;
  logic                 w_pickValid;

  assign w_cand      = proc_ativo & ~r_fimMask;
  assign w_curOneHot = NUM_PROC'(1) << r_procAtual;
  assign w_curAtivo  = |(proc_ativo & w_curOneHot);
  // A zero quantum behaves as one, so the last count is 0 in that case.
  assign w_qLast     = (quantum == '0) ? '0 : quantum - QUANTUM_W'(1);

  rr_arbiter #(
    .NUM_PROC (NUM_PROC)
  ) u_arbiter (
    .i_cand  (w_cand),
    .i_start (r_procAtual),
    .i_incl  (r_first),
    .o_pick  (w_pick),
    .o_valid (w_pickValid)
  );

  // Scheduler FSM with registered outputs, slice counter and finish mask.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_trocaReq  <= 1'b0;
      r_hdSet     <= '0;
      r_procAtual <= '0;
      r_ocioso    <= 1'b1;
      r_cnt       <= '0;
      r_fimMask   <= '0;
      r_first     <= 1'b1;
      r_needLoad  <= 1'b1;
    end else begin
      r_fimMask <= r_fimMask & proc_ativo;
      unique case (r_state)
        IDLE: begin
          if (|w_cand) begin
            r_state  <= SELECT;
            r_ocioso <= 1'b0;
          end
        end
        SELECT: begin
          if (!w_pickValid) begin
            r_state    <= IDLE;
            r_ocioso   <= 1'b1;
            r_needLoad <= 1'b1;
          end else begin
            r_first <= 1'b0;
            if ((w_pick == r_procAtual) && !r_needLoad) begin
              r_cnt   <= '0;
              r_state <= RUN;
            end else begin
              r_hdSet    <= w_pick;
              r_trocaReq <= 1'b1;
              r_state    <= SWITCH;
            end
          end
        end
        SWITCH: begin
          if (troca_ack) begin
            r_procAtual <= r_hdSet;
            r_trocaReq  <= 1'b0;
            r_cnt       <= '0;
            r_needLoad  <= 1'b0;
            r_state     <= RUN;
          end
        end
        RUN: begin
          if (proc_fim) begin
            r_fimMask <= (r_fimMask | w_curOneHot) & proc_ativo;
            r_cnt     <= '0;
            r_state   <= SELECT;
          end else if (!w_curAtivo) begin
            r_cnt   <= '0;
            r_state <= SELECT;
          end else if (instr_done) begin
            if (r_cnt >= w_qLast) begin
              r_cnt   <= '0;
              r_state <= SELECT;
            end else begin
              r_cnt <= r_cnt + QUANTUM_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign troca_req      = r_trocaReq;
  assign hd_set         = r_hdSet;
  assign processo_atual = r_procAtual;
  assign ocioso         = r_ocioso;

`ifdef ESCALONADOR_STATS_EN
  logic [15:0] r_trocasCnt;

  // Count every handshake the control unit accepts; wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_trocasCnt <= '0;
    end else if ((r_state == SWITCH) && troca_ack) begin
      r_trocasCnt <= r_trocasCnt + 16'd1;
    end
  end

  assign trocas_cnt = r_trocasCnt;
`endif

endmodule

// File: tb/tb_escalonador.sv
// Self-checking bench for the escalonador scheduler. Expected hd_set values
// are queued when a switch is provoked and checked by an independent monitor
// each time troca_req rises.
module tb_escalonador;

  logic        clk;
  logic        reset;
  logic [4:0]  proc_ativo;
  logic [15:0] quantum;
  logic        instr_done;
  logic        proc_fim;
  logic        troca_ack;
  logic        troca_req;
  logic [9:0]  hd_set;
  logic [9:0]  processo_atual;
  logic        ocioso;
`ifdef ESCALONADOR_STATS_EN
  logic [15:0] trocas_cnt;
`endif

  int          checks;
  int          failures;
  bit          ackEnable;
  logic [9:0]  expQ[$];

  escalonador #(
    .NUM_PROC  (5),
    .QUANTUM_W (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .proc_ativo     (proc_ativo),
    .quantum        (quantum),
    .instr_done     (instr_done),
    .proc_fim       (proc_fim),
    .troca_ack      (troca_ack),
    .troca_req      (troca_req),
    .hd_set         (hd_set),
    .processo_atual (processo_atual),
    .ocioso         (ocioso)
`ifdef ESCALONADOR_STATS_EN
    ,
    .trocas_cnt     (trocas_cnt)
`endif
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something never settles.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] ativo, input logic [15:0] q);
    @(negedge clk);
    proc_ativo = ativo;
    quantum    = q;
  endtask

  task automatic pulseInstr(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      instr_done = 1'b1;
      @(negedge clk);
      instr_done = 1'b0;
    end
  endtask

  task automatic waitSwitch(input logic [9:0] expId);
    int n;
    n = 0;
    while (!troca_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_seen", {31'd0, troca_req}, 32'd1);
    n = 0;
    while (troca_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("switch_done", {31'd0, troca_req}, 32'd0);
    checkOutput("processo_atual", {22'd0, processo_atual}, {22'd0, expId});
  endtask

  // Automatic control-unit model: acks one cycle after seeing a request.
  initial begin
    troca_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ackEnable && troca_req && !troca_ack) troca_ack = 1'b1;
      else troca_ack = 1'b0;
    end
  end

  // Monitor: every new switch request must match the next queued id.
  initial begin
    logic       prevReq;
    logic [9:0] expId;
    prevReq = 1'b0;
    forever begin
      @(negedge clk);
      if (troca_req && !prevReq) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_req: got hd_set=%0d expected no request", hd_set);
        end else begin
          expId = expQ.pop_front();
          checkOutput("hd_set", {22'd0, hd_set}, {22'd0, expId});
        end
      end
      prevReq = troca_req;
    end
  end

  // Directed scenarios.
  initial begin
    int n;
    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    proc_ativo = 5'b00000;
    quantum    = 16'd3;
    instr_done = 1'b0;
    proc_fim   = 1'b0;
    ackEnable  = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_troca_req", {31'd0, troca_req}, 32'd0);
    checkOutput("rst_hd_set", {22'd0, hd_set}, 32'd0);
    checkOutput("rst_processo_atual", {22'd0, processo_atual}, 32'd0);
    checkOutput("rst_ocioso", {31'd0, ocioso}, 32'd1);
`ifdef ESCALONADOR_STATS_EN
    checkOutput("rst_trocas_cnt", {16'd0, trocas_cnt}, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_no_cand", {31'd0, ocioso}, 32'd1);

    // First switch after reset, latency of two cycles.
    @(negedge clk);
    proc_ativo = 5'b00101;
    expQ.push_back(10'd0);
    @(negedge clk);
    checkOutput("req_lat1", {31'd0, troca_req}, 32'd0);
    checkOutput("ocioso_left", {31'd0, ocioso}, 32'd0);
    @(negedge clk);
    checkOutput("req_lat2", {31'd0, troca_req}, 32'd1);
    @(negedge clk);
    checkOutput("first_load", {22'd0, processo_atual}, 32'd0);
    checkOutput("req_dropped", {31'd0, troca_req}, 32'd0);

    // Quantum 3 round robin between ids 0 and 2.
    expQ.push_back(10'd2);
    pulseInstr(2);
    @(negedge clk);
    checkOutput("no_early_expiry", {31'd0, troca_req}, 32'd0);
    pulseInstr(1);
    waitSwitch(10'd2);
    expQ.push_back(10'd0);
    pulseInstr(3);
    waitSwitch(10'd0);

    // Current process deactivated, then only id 1 runnable.
    expQ.push_back(10'd1);
    applyStimulus(5'b00010, 16'd2);
    waitSwitch(10'd1);
    pulseInstr(2);
    repeat (3) @(negedge clk);
    checkOutput("same_pick_stay", {22'd0, processo_atual}, 32'd1);
    checkOutput("same_pick_no_req", {31'd0, troca_req}, 32'd0);
    applyStimulus(5'b00011, 16'd2);
    pulseInstr(1);
    repeat (2) @(negedge clk);
    checkOutput("cnt_restart", {22'd0, processo_atual}, 32'd1);
    expQ.push_back(10'd0);
    pulseInstr(1);
    waitSwitch(10'd0);

    // proc_fim together with expiry masks id 0 until it is toggled.
    pulseInstr(1);
    expQ.push_back(10'd1);
    @(negedge clk);
    instr_done = 1'b1;
    proc_fim   = 1'b1;
    @(negedge clk);
    instr_done = 1'b0;
    proc_fim   = 1'b0;
    waitSwitch(10'd1);
    pulseInstr(2);
    repeat (3) @(negedge clk);
    checkOutput("masked_skip1", {22'd0, processo_atual}, 32'd1);
    pulseInstr(2);
    repeat (3) @(negedge clk);
    checkOutput("masked_skip2", {22'd0, processo_atual}, 32'd1);
    applyStimulus(5'b00010, 16'd2);
    applyStimulus(5'b00011, 16'd2);
    expQ.push_back(10'd0);
    pulseInstr(2);
    waitSwitch(10'd0);

    // Quantum 0 expires on every instruction.
    applyStimulus(5'b00011, 16'd0);
    expQ.push_back(10'd1);
    pulseInstr(1);
    waitSwitch(10'd1);
    expQ.push_back(10'd0);
    pulseInstr(1);
    waitSwitch(10'd0);
`ifdef ESCALONADOR_STATS_EN
    checkOutput("trocas_cnt_9", {16'd0, trocas_cnt}, 32'd9);
`endif

    // Withheld ack, then reset in the middle of the handshake.
    ackEnable = 1'b0;
    applyStimulus(5'b00011, 16'd1);
    expQ.push_back(10'd1);
    pulseInstr(1);
    n = 0;
    while (!troca_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_raised", {31'd0, troca_req}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("req_hold", {31'd0, troca_req}, 32'd1);
      checkOutput("hd_hold", {22'd0, hd_set}, 32'd1);
    end
    #2;
    reset = 1'b0;
    #1;
    checkOutput("req_async_drop", {31'd0, troca_req}, 32'd0);
    checkOutput("ocioso_on_reset", {31'd0, ocioso}, 32'd1);
    checkOutput("atual_on_reset", {22'd0, processo_atual}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("req_stays_low", {31'd0, troca_req}, 32'd0);
    end
`ifdef ESCALONADOR_STATS_EN
    checkOutput("trocas_cnt_reset", {16'd0, trocas_cnt}, 32'd0);
`endif
    proc_ativo = 5'b00000;
    @(negedge clk);
    reset     = 1'b1;
    ackEnable = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_after_reset", {31'd0, ocioso}, 32'd1);

    // Four accepted switches after reset.
    expQ.push_back(10'd0);
    applyStimulus(5'b00011, 16'd0);
    waitSwitch(10'd0);
    expQ.push_back(10'd1);
    pulseInstr(1);
    waitSwitch(10'd1);
    expQ.push_back(10'd0);
    pulseInstr(1);
    waitSwitch(10'd0);
    expQ.push_back(10'd1);
    pulseInstr(1);
    waitSwitch(10'd1);
`ifdef ESCALONADOR_STATS_EN
    checkOutput("trocas_cnt_4", {16'd0, trocas_cnt}, 32'd4);
`endif

    repeat (3) @(negedge clk);
    checkOutput("queue_empty", expQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/escalonador.md
ESCALONADOR -- requirements
Module: escalonador

Interface
REQ-001 SHALL have parameter NUM_PROC, default 5: number of process slots, legal range 1..5, ids 0..NUM_PROC-1.
REQ-002 SHALL have parameter QUANTUM_W, default 16: width of the quantum and slice counter.
REQ-003 SHALL have port clk, in, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, in, 1: asynchronous, active-low reset.
REQ-005 SHALL have port proc_ativo, in, NUM_PROC: bit i=1 means process i is runnable.
REQ-006 SHALL have port quantum, in, QUANTUM_W: time slice in retired instructions; 0 is treated as 1.
REQ-007 SHALL have port instr_done, in, 1: one-cycle pulse per instruction retired by the current process.
REQ-008 SHALL have port proc_fim, in, 1: the current process executed its last instruction.
REQ-009 SHALL have port troca_ack, in, 1: the control unit accepted the switch and issued the process-load PC command.
REQ-010 SHALL have port troca_req, out, 1: switch request.
REQ-011 SHALL have port hd_set, out, 10: id of the process to load, zero-extended.
REQ-012 SHALL have port processo_atual, out, 10: id of the running process.
REQ-013 SHALL have port ocioso, out, 1: no runnable process.

Function
REQ-014 SHALL implement the states IDLE, SELECT, SWITCH and RUN.
REQ-015 IDLE: ocioso=1; any candidate (proc_ativo & ~fim_mask) nonzero SHALL move to SELECT on the next edge.
REQ-016 SELECT lasts one cycle and picks the lowest candidate id strictly above processo_atual, wrapping, with the current id as last choice; no candidate -> IDLE.
REQ-017 On the first SELECT after reset, the search SHALL start at id 0 inclusive.
REQ-018 SELECT with pick != processo_atual (or first after reset/IDLE) SHALL drive hd_set=pick, assert troca_req and go to SWITCH.
REQ-019 SELECT with pick == processo_atual SHALL skip the handshake, clear the counter and return to RUN.
REQ-020 SWITCH SHALL hold troca_req=1 and hd_set stable until troca_ack=1 is sampled.
REQ-021 On that ack edge: processo_atual<=hd_set, troca_req<=0, counter<=0, next state RUN; troca_ack outside SWITCH is ignored.
REQ-022 RUN: instr_done SHALL increment the counter; instr_done with counter==max(quantum,1)-1 is expiry -> SELECT.
REQ-023 RUN: proc_fim SHALL set fim_mask[processo_atual] and go to SELECT; proc_fim wins over a simultaneous expiry.
REQ-024 RUN: proc_ativo[processo_atual] falling SHALL go to SELECT without setting fim_mask.
REQ-025 fim_mask bit i SHALL clear whenever proc_ativo[i]=0, so the slot can be reused.
REQ-026 instr_done and proc_fim SHALL be ignored outside RUN.
REQ-027 Latency from a candidate appearing in IDLE to troca_req=1 SHALL be 2 cycles.

Reset
REQ-028 Reset assertion SHALL immediately force: state IDLE, troca_req=0, hd_set=0, processo_atual=0, ocioso=1, counter=0, fim_mask=0, first-select flag=1.
REQ-029 Reset mid-handshake SHALL drop troca_req asynchronously without waiting for troca_ack.

Configuration
REQ-030 With ESCALONADOR_STATS_EN defined, SHALL add output trocas_cnt[15:0], reset 0, +1 per accepted handshake, wrapping at 16'hFFFF to 0; without it, the port and logic SHALL be absent.

Structure
REQ-031 Package escalonador_pkg SHALL hold the state enum, PROC_ID_W=10 and NUM_PROC_MAX=5.
REQ-032 The round-robin pick SHALL be a combinational sub-module rr_arbiter (inputs: candidate mask, start id, include-start flag; outputs: pick, valid).

Verification
REQ-033 Reset release, proc_ativo=5'b00101, ack 1 cycle after req: hd_set=0 then processo_atual=0; troca_req rises exactly 2 cycles after proc_ativo.
REQ-034 quantum=3, proc_ativo=5'b00101, 3 instr_done pulses: switch to id 2, then after 3 more back to id 0.
REQ-035 Only id 1 runnable, quantum=2: expiry gives no troca_req, counter restarts, processo_atual stays 1.
REQ-036 proc_fim and expiry same cycle on id 0, proc_ativo=5'b00011: id 0 masked, switch to 1, id 0 never reselected until proc_ativo[0] toggles 0->1.
REQ-037 troca_ack withheld 10 cycles: troca_req/hd_set stable throughout; reset asserted on cycle 5: troca_req=0 at once, ocioso=1.
REQ-038 With ESCALONADOR_STATS_EN: 4 accepted switches give trocas_cnt=4; quantum=0 expires on every instr_done.
